vj_det_merger: RTL and testbench

- Sits directly downstream of the 19x19 detector top and consumes its det_valid/det_x/det_y/det_w/det_h stream plus its busy flag.
- Collects each frame's raw window hits into an on-chip table of up to MAX_DET entries.
- Suppresses near-duplicate hits, since adjacent windows fire on the same face, and counts how many hits merged into each entry.
- After the frame's scan ends, drains the table through a valid/ready stream and emits a one-cycle frame summary.

---
 rtl/vj_det_pkg.sv | 31 +++
 rtl/vj_det_merger_if.sv | 26 ++
 rtl/vj_det_match.sv | 32 +++
 rtl/vj_det_merger.sv | 201 ++++++++++++++++++++
 tb/tb_vj_det_merger.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/vj_det_pkg.sv
// Shared definitions for the detection merger: coordinate widths, FSM
// encoding, packed table-entry layout and a distance helper.
package vj_det_pkg;

  localparam int X_W    = 10;
  localparam int Y_W    = 9;
  localparam int DIFF_W = 11;

  // Packed entry layout: {hits, h, w, y, x}, x in the low bits.
  localparam int ENT_X_LSB    = 0;
  localparam int ENT_Y_LSB    = ENT_X_LSB + X_W;
  localparam int ENT_W_LSB    = ENT_Y_LSB + Y_W;
  localparam int ENT_H_LSB    = ENT_W_LSB + X_W;
  localparam int ENT_HITS_LSB = ENT_H_LSB + Y_W;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_FLUSH   = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  // |a - b| using an 11-bit signed difference (y callers zero-extend to X_W).
  function automatic logic [DIFF_W-1:0] abs_diff(input logic [X_W-1:0] a,
                                                 input logic [X_W-1:0] b);
    logic signed [DIFF_W-1:0] d;
    d = $signed({1'b0, a}) - $signed({1'b0, b});
    return d[DIFF_W-1] ? -d : d;
  endfunction

endpackage

// File: rtl/vj_det_merger_if.sv
// Output stream of merged detections.
// Handshake: a beat transfers on a rising clk edge where out_valid && out_ready;
// while out_valid is high and out_ready is low, every payload field holds.
interface vj_det_merger_if #(parameter int HIT_W = 8);
  import vj_det_pkg::*;

  logic             out_valid;
  logic             out_ready;
  logic [X_W-1:0]   out_x;
  logic [Y_W-1:0]   out_y;
  logic [X_W-1:0]   out_w;
  logic [Y_W-1:0]   out_h;
  logic [HIT_W-1:0] out_hits;
  logic             out_last;

  modport master (
    output out_valid, out_x, out_y, out_w, out_h, out_hits, out_last,
    input  out_ready
  );

  modport slave (
    input  out_valid, out_x, out_y, out_w, out_h, out_hits, out_last,
    output out_ready
  );

endinterface

// File: rtl/vj_det_match.sv
// Compares one stored table entry against the incoming raw hit: same size and
// both coordinate distances within DIST_THR.
module vj_det_match
  import vj_det_pkg::*;
#(
  parameter int DIST_THR = 4
) (
  input  logic           ent_valid,
  input  logic [X_W-1:0] ent_x,
  input  logic [Y_W-1:0] ent_y,
  input  logic [X_W-1:0] ent_w,
  input  logic [Y_W-1:0] ent_h,
  input  logic [X_W-1:0] hit_x,
  input  logic [Y_W-1:0] hit_y,
  input  logic [X_W-1:0] hit_w,
  input  logic [Y_W-1:0] hit_h,
  output logic           match
);

  logic [DIFF_W-1:0] dx;
  logic [DIFF_W-1:0] dy;

  assign dx = abs_diff(hit_x, ent_x);
  assign dy = abs_diff({1'b0, hit_y}, {1'b0, ent_y});

  assign match = ent_valid
              && (hit_w == ent_w)
              && (hit_h == ent_h)
              && (dx <= DIFF_W'(DIST_THR))
              && (dy <= DIFF_W'(DIST_THR));

endmodule

// File: rtl/vj_det_merger.sv
// Collects a frame's raw window hits into a small table, merging near
// duplicates, then drains the table as a stream and pulses a frame summary.
module vj_det_merger
  import vj_det_pkg::*;
#(
  parameter int MAX_DET  = 16,
  parameter int IDX_W    = 4,
  parameter int DIST_THR = 4,
  parameter int HIT_W    = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             det_valid,
  input  logic [X_W-1:0]   det_x,
  input  logic [Y_W-1:0]   det_y,
  input  logic [X_W-1:0]   det_w,
  input  logic [Y_W-1:0]   det_h,
  input  logic             det_busy,
  vj_det_merger_if.master  stream,
  output logic             frame_done,
  output logic [IDX_W:0]   frame_count,
  output logic             frame_ovf,
  output logic             busy,
  output state_t           fsm_state
);

  localparam int              ENT_BITS = ENT_HITS_LSB + HIT_W;
  localparam logic [IDX_W:0]  MAX_CNT  = (IDX_W+1)'(MAX_DET);
  localparam logic [IDX_W:0]  CNT_ONE  = (IDX_W+1)'(1);
  localparam logic [HIT_W-1:0] HIT_MAX = '1;

  logic [ENT_BITS-1:0] tbl [MAX_DET];
  logic [IDX_W:0]      count;
  logic [IDX_W:0]      eff_count;
  logic [IDX_W-1:0]    ptr;
  logic [IDX_W-1:0]    nxt_ptr;
  logic [IDX_W-1:0]    hit_idx;
  logic [HIT_W-1:0]    hit_hits;
  logic [MAX_DET-1:0]  match_vec;
  logic [ENT_BITS-1:0] new_ent;
  logic [ENT_BITS-1:0] rd_ent;
  logic                rd_last;
  logic                ovf;
  logic                ovf_next;
  logic                busy_d;
  logic                rise;
  logic                fall;
  logic                start;
  logic                collecting;
  logic                any_match;
  logic                drop_new;

  assign rise       = det_busy && !busy_d;
  assign fall       = !det_busy && busy_d;
  assign start      = (fsm_state == ST_IDLE) && (rise || det_valid);
  assign collecting = start || (fsm_state == ST_COLLECT);
  // A new frame starts with an empty table, so IDLE matches against nothing.
  assign eff_count  = (fsm_state == ST_IDLE) ? '0 : count;
  assign new_ent    = {HIT_W'(1), det_h, det_w, det_y, det_x};
  assign hit_hits   = tbl[hit_idx][ENT_HITS_LSB +: HIT_W];
  assign nxt_ptr    = ptr + IDX_W'(1);

  // While a beat is held the next entry is preloaded after a transfer.
  assign rd_ent  = stream.out_valid ? tbl[nxt_ptr] : tbl[ptr];
  assign rd_last = stream.out_valid ? ({1'b0, nxt_ptr} == (count - CNT_ONE))
                                    : ({1'b0, ptr} == (count - CNT_ONE));

  for (genvar i = 0; i < MAX_DET; i++) begin : g_match
    vj_det_match #(.DIST_THR(DIST_THR)) u_match (
      .ent_valid ((IDX_W+1)'(i) < eff_count),
      .ent_x     (tbl[i][ENT_X_LSB +: X_W]),
      .ent_y     (tbl[i][ENT_Y_LSB +: Y_W]),
      .ent_w     (tbl[i][ENT_W_LSB +: X_W]),
      .ent_h     (tbl[i][ENT_H_LSB +: Y_W]),
      .hit_x     (det_x),
      .hit_y     (det_y),
      .hit_w     (det_w),
      .hit_h     (det_h),
      .match     (match_vec[i])
    );
  end

  // Priority encoder: the lowest matching index wins.
  always_comb begin
    any_match = 1'b0;
    hit_idx   = '0;
    for (int i = MAX_DET - 1; i >= 0; i--) begin
      if (match_vec[i]) begin
        any_match = 1'b1;
        hit_idx   = IDX_W'(i);
      end
    end
  end

  // Overflow flag: cleared at frame start, set by a full-table drop or by any
  // hit arriving while the table is being drained or reported.
  always_comb begin
    drop_new = collecting && det_valid && !any_match && (eff_count == MAX_CNT);
    ovf_next = ((fsm_state == ST_IDLE) ? 1'b0 : ovf)
             | drop_new
             | (det_valid && ((fsm_state == ST_FLUSH) || (fsm_state == ST_DONE)));
  end

  // Frame FSM, table updates and all registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fsm_state        <= ST_IDLE;
      count            <= '0;
      ptr              <= '0;
      ovf              <= 1'b0;
      busy_d           <= 1'b0;
      busy             <= 1'b0;
      frame_done       <= 1'b0;
      frame_count      <= '0;
      frame_ovf        <= 1'b0;
      stream.out_valid <= 1'b0;
      stream.out_last  <= 1'b0;
      stream.out_x     <= '0;
      stream.out_y     <= '0;
      stream.out_w     <= '0;
      stream.out_h     <= '0;
      stream.out_hits  <= '0;
      for (int i = 0; i < MAX_DET; i++) tbl[i] <= '0;
    end else begin
      busy_d <= det_busy;

      case (fsm_state)
        ST_IDLE: begin
          if (start) begin
            count     <= '0;
            ovf       <= ovf_next;
            busy      <= 1'b1;
            fsm_state <= ST_COLLECT;
          end
        end

        ST_COLLECT: begin
          ovf <= ovf_next;
          if (fall) begin
            if ((count == '0) && !det_valid) begin
              busy        <= 1'b0;
              frame_done  <= 1'b1;
              frame_count <= '0;
              frame_ovf   <= ovf_next;
              fsm_state   <= ST_DONE;
            end else begin
              ptr       <= '0;
              fsm_state <= ST_FLUSH;
            end
          end
        end

        ST_FLUSH: begin
          ovf <= ovf_next;
          if (!stream.out_valid || stream.out_ready) begin
            if (stream.out_valid && stream.out_last) begin
              stream.out_valid <= 1'b0;
              stream.out_last  <= 1'b0;
              busy             <= 1'b0;
              frame_done       <= 1'b1;
              frame_count      <= count;
              frame_ovf        <= ovf_next;
              fsm_state        <= ST_DONE;
            end else begin
              if (stream.out_valid) ptr <= nxt_ptr;
              stream.out_valid <= 1'b1;
              stream.out_last  <= rd_last;
              stream.out_x     <= rd_ent[ENT_X_LSB +: X_W];
              stream.out_y     <= rd_ent[ENT_Y_LSB +: Y_W];
              stream.out_w     <= rd_ent[ENT_W_LSB +: X_W];
              stream.out_h     <= rd_ent[ENT_H_LSB +: Y_W];
              stream.out_hits  <= rd_ent[ENT_HITS_LSB +: HIT_W];
            end
          end
        end

        ST_DONE: begin
          ovf         <= ovf_next;
          frame_done  <= 1'b0;
          frame_count <= '0;
          frame_ovf   <= 1'b0;
          fsm_state   <= ST_IDLE;
        end

        default: fsm_state <= ST_IDLE;
      endcase

      // Table write comes last so a hit in the start cycle overrides the clear.
      if (collecting && det_valid) begin
        if (any_match) begin
          if (hit_hits != HIT_MAX)
            tbl[hit_idx][ENT_HITS_LSB +: HIT_W] <= hit_hits + HIT_W'(1);
        end else if (eff_count < MAX_CNT) begin
          tbl[eff_count[IDX_W-1:0]] <= new_ent;
          count                     <= eff_count + CNT_ONE;
        end
      end
    end
  end

endmodule

// File: tb/tb_vj_det_merger.sv
// Directed bench for the detection merger: merging, size/distance limits,
// table overflow, hit saturation, empty frames, stalls and reset mid-drain.
module tb_vj_det_merger;
  import vj_det_pkg::*;

  logic           clk = 1'b0;
  logic           reset;
  logic           det_valid;
  logic [X_W-1:0] det_x;
  logic [Y_W-1:0] det_y;
  logic [X_W-1:0] det_w;
  logic [Y_W-1:0] det_h;
  logic           det_busy;
  logic           frame_done;
  logic [4:0]     frame_count;
  logic           frame_ovf;
  logic           busy;
  state_t         fsm_state;

  int checks = 0;
  int errors = 0;

  vj_det_merger_if #(.HIT_W(8)) stream ();

  vj_det_merger dut (
    .clk         (clk),
    .reset       (reset),
    .det_valid   (det_valid),
    .det_x       (det_x),
    .det_y       (det_y),
    .det_w       (det_w),
    .det_h       (det_h),
    .det_busy    (det_busy),
    .stream      (stream.master),
    .frame_done  (frame_done),
    .frame_count (frame_count),
    .frame_ovf   (frame_ovf),
    .busy        (busy),
    .fsm_state   (fsm_state)
  );

  // Clock
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic hit(input int x, input int y, input int w, input int h);
    det_valid = 1'b1;
    det_x = X_W'(x);
    det_y = Y_W'(y);
    det_w = X_W'(w);
    det_h = Y_W'(h);
    tick();
    det_valid = 1'b0;
  endtask

  task automatic busy_on();
    det_busy = 1'b1;
    tick();
  endtask

  task automatic busy_off();
    det_busy = 1'b0;
    tick();
  endtask

  // Waits (bounded) for a beat, checks it against the expected entry, accepts it.
  task automatic drain_one(input string tag, input int x, input int y, input int w,
                           input int h, input int hits, input int last);
    int n = 0;
    while (!stream.out_valid && n < 20) begin
      tick();
      n++;
    end
    check({tag, ".valid"}, 32'(stream.out_valid), 1);
    check({tag, ".x"},     32'(stream.out_x),     32'(x));
    check({tag, ".y"},     32'(stream.out_y),     32'(y));
    check({tag, ".w"},     32'(stream.out_w),     32'(w));
    check({tag, ".h"},     32'(stream.out_h),     32'(h));
    check({tag, ".hits"},  32'(stream.out_hits),  32'(hits));
    check({tag, ".last"},  32'(stream.out_last),  32'(last));
    stream.out_ready = 1'b1;
    tick();
    stream.out_ready = 1'b0;
  endtask

  // Expects the DONE cycle now, then its end one cycle later.
  task automatic frame_end(input string tag, input int cnt, input int ovf);
    check({tag, ".done"},  32'(frame_done),  1);
    check({tag, ".count"}, 32'(frame_count), 32'(cnt));
    check({tag, ".ovf"},   32'(frame_ovf),   32'(ovf));
    check({tag, ".busy"},  32'(busy),        0);
    check({tag, ".valid"}, 32'(stream.out_valid), 0);
    tick();
    check({tag, ".done_pulse"}, 32'(frame_done), 0);
    check({tag, ".idle"},  32'(fsm_state), 32'(ST_IDLE));
  endtask

  task automatic run_basic(input string tag);
    busy_on();
    check({tag, ".busy"}, 32'(busy), 1);
    hit(100, 50, 19, 19);
    hit(102, 52, 19, 19);
    hit(200, 50, 19, 19);
    busy_off();
    drain_one({tag, ".e0"}, 100, 50, 19, 19, 2, 0);
    drain_one({tag, ".e1"}, 200, 50, 19, 19, 1, 1);
    frame_end(tag, 2, 0);
  endtask

  initial begin
    // Reset
    reset = 1'b1;
    det_valid = 1'b0;
    det_x = '0;
    det_y = '0;
    det_w = '0;
    det_h = '0;
    det_busy = 1'b0;
    stream.out_ready = 1'b0;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    check("rst.valid", 32'(stream.out_valid), 0);
    check("rst.last",  32'(stream.out_last),  0);
    check("rst.done",  32'(frame_done),       0);
    check("rst.ovf",   32'(frame_ovf),        0);
    check("rst.count", 32'(frame_count),      0);
    check("rst.busy",  32'(busy),             0);
    check("rst.state", 32'(fsm_state),        32'(ST_IDLE));

    // 1: basic merge
    run_basic("s1");

    // 2: size mismatch, distance limits, lowest-index priority
    busy_on();
    hit(100, 50, 19, 19);  // e0
    hit(100, 50, 23, 23);  // e1: size differs
    hit(105, 50, 19, 19);  // e2: dx=5
    hit(104, 50, 19, 19);  // e0 (dx=4) though e2 also matches
    hit(100, 55, 19, 19);  // e3: dy=5
    hit(96, 46, 19, 19);   // e0: dx=-4, dy=-4
    busy_off();
    drain_one("s2.e0", 100, 50, 19, 19, 3, 0);
    drain_one("s2.e1", 100, 50, 23, 23, 1, 0);
    drain_one("s2.e2", 105, 50, 19, 19, 1, 0);
    drain_one("s2.e3", 100, 55, 19, 19, 1, 1);
    frame_end("s2", 4, 0);

    // 3: table overflow and hit saturation
    busy_on();
    for (int i = 0; i < 17; i++) hit(20 * i, 10, 19, 19);
    for (int i = 0; i < 300; i++) hit(0, 10, 19, 19);
    busy_off();
    for (int i = 0; i < 16; i++)
      drain_one($sformatf("s3.e%0d", i), 20 * i, 10, 19, 19,
                (i == 0) ? 255 : 1, (i == 15) ? 1 : 0);
    frame_end("s3", 16, 1);

    // 4: empty frame
    busy_on();
    tick();
    busy_off();
    frame_end("s4", 0, 0);

    // 5: coincident hit on the falling edge, stall, hit during drain
    busy_on();
    hit(10, 10, 19, 19);
    hit(50, 10, 19, 19);
    hit(90, 10, 19, 19);
    det_busy = 1'b0;
    hit(130, 10, 19, 19);
    drain_one("s5.e0", 10, 10, 19, 19, 1, 0);
    hit(500, 100, 19, 19);
    for (int i = 0; i < 10; i++) begin
      tick();
      check($sformatf("s5.stall%0d.valid", i), 32'(stream.out_valid), 1);
      check($sformatf("s5.stall%0d.x", i),     32'(stream.out_x),     50);
    end
    drain_one("s5.e1", 50, 10, 19, 19, 1, 0);
    drain_one("s5.e2", 90, 10, 19, 19, 1, 0);
    drain_one("s5.e3", 130, 10, 19, 19, 1, 1);
    frame_end("s5", 4, 1);

    // 6: reset in the middle of a drain
    busy_on();
    hit(100, 50, 19, 19);
    hit(200, 50, 19, 19);
    busy_off();
    tick();
    check("s6.pre_valid", 32'(stream.out_valid), 1);
    #2 reset = 1'b1;
    #1;
    check("s6.async_valid", 32'(stream.out_valid), 0);
    check("s6.async_busy",  32'(busy),             0);
    check("s6.async_state", 32'(fsm_state),        32'(ST_IDLE));
    tick();
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check($sformatf("s6.no_done%0d", i), 32'(frame_done), 0);
    end
    run_basic("s6.next");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
